pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register that generalises the per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block.
- Carries an opaque payload vector plus a valid bit and a one-bit sticky side-flag (e.g. next-instruction-in-delay-slot).
- Honours the global 6-bit stall vector and a flush input.
- Inserts bubbles when the upstream stage stalls and the downstream stage does not.
- Instantiated once per stage boundary, with STAGE selecting its position in the stall vector.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 91 +++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector type, stall encodings
// and stage indices into the stall vector.
package pipe_pkg;

    localparam int STALL_W_DEF = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    typedef logic [STALL_W_DEF-1:0] stall_t;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Stops at all-ones and never wraps.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/flush/bubble handling.
// Define PIPE_STAGE_PERF_EN to add bubble/hold performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 128,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                STAGE   = 2,
    parameter int                STALL_W = STALL_W_DEF,
    parameter int                CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic               in_valid,
    input  logic               in_sticky,
    output logic [DATA_W-1:0]  out_payload,
    output logic               out_valid,
`ifdef PIPE_STAGE_PERF_EN
    output logic               out_sticky,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
`else
    output logic               out_sticky
`endif
);

    if (STAGE < 0 || STAGE > STALL_W - 2 || DATA_W < 1) begin : g_bad_param
        $fatal(1, "pipe_stage_reg: STAGE or DATA_W out of range");
    end

    logic up;
    logic dn;
    logic do_bubble;
    logic do_hold;
    logic stall_unused;

    assign up           = stall[STAGE];
    assign dn           = stall[STAGE+1];
    assign do_bubble    = (up == STOP) && (dn == NOSTOP);
    assign do_hold      = (up == STOP) && (dn == STOP);
    assign stall_unused = ^stall;

    // Bubble keeps the sticky flag so delay-slot state outlives a load-use stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_payload <= NOP_VAL;
            out_valid   <= 1'b0;
            out_sticky  <= 1'b0;
        end else if (do_bubble) begin
            out_payload <= NOP_VAL;
            out_valid   <= 1'b0;
        end else if (up == NOSTOP) begin
            out_payload <= in_payload;
            out_valid   <= in_valid;
            out_sticky  <= in_sticky;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((up == NOSTOP) && (dn == STOP)))
            else $error("pipe_stage_reg: non-monotone stall vector");
        end
    end
`endif

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_bubble && !flush),
        .count (bubble_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_hold && !flush),
        .count (hold_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (STAGE=2, CNT_W=4).
// Counter checks are compiled in only with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic [DATA_W-1:0] in_payload;
    logic              in_valid;
    logic              in_sticky;
    logic [DATA_W-1:0] out_payload;
    logic              out_valid;
    logic              out_sticky;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  hold_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .NOP_VAL ('0),
        .STAGE   (2),
        .STALL_W (6),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_payload  (in_payload),
        .in_valid    (in_valid),
        .in_sticky   (in_sticky),
        .out_payload (out_payload),
        .out_valid   (out_valid),
`ifdef PIPE_STAGE_PERF_EN
        .out_sticky  (out_sticky),
        .bubble_cnt  (bubble_cnt),
        .hold_cnt    (hold_cnt)
`else
        .out_sticky  (out_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [DATA_W-1:0] p, input logic v, input logic s);
        check({tag, ".payload"}, 128'(out_payload), 128'(p));
        check({tag, ".valid"}, 128'(out_valid), 128'(v));
        check({tag, ".sticky"}, 128'(out_sticky), 128'(s));
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic check_cnt(input string tag, input int b, input int h);
        check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(b));
        check({tag, ".hold_cnt"}, 128'(hold_cnt), 128'(h));
    endtask
`endif

    initial begin
        rst        = 1'b1;
        stall      = 6'b000000;
        flush      = 1'b0;
        in_payload = 64'hDEAD_BEEF_DEAD_BEEF;
        in_valid   = 1'b1;
        in_sticky  = 1'b1;
        step();
        step();
        check_out("reset", 64'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("reset", 0, 0);
`endif

        // Advance
        rst        = 1'b0;
        in_payload = 64'h1234;
        step();
        check_out("advance", 64'h1234, 1'b1, 1'b1);

        // Bubble: up=1, dn=0, sticky held
        stall      = 6'b000111;
        in_payload = 64'h5555;
        in_sticky  = 1'b0;
        step();
        check_out("bubble", 64'h0, 1'b0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("bubble", 1, 0);
`endif

        // Load a real value before holding
        stall      = 6'b000000;
        in_payload = 64'hAAAA;
        in_valid   = 1'b1;
        in_sticky  = 1'b0;
        step();
        check_out("advance2", 64'hAAAA, 1'b1, 1'b0);

        // Hold three cycles with changing input
        stall = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            in_payload = 64'h100 + 64'(i);
            in_valid   = 1'b0;
            in_sticky  = 1'b1;
            step();
            check_out("hold", 64'hAAAA, 1'b1, 1'b0);
        end
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("hold", 1, 3);
`endif

        // Sticky=1 then flush during hold clears everything
        stall      = 6'b000000;
        in_payload = 64'h77;
        in_valid   = 1'b1;
        in_sticky  = 1'b1;
        step();
        check_out("advance3", 64'h77, 1'b1, 1'b1);
        stall = 6'b001111;
        flush = 1'b1;
        step();
        check_out("flush_hold", 64'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("flush_hold", 1, 3);
`endif

        // Flush overrides bubble; no bubble counted
        stall = 6'b000111;
        step();
        check_out("flush_bubble", 64'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("flush_bubble", 1, 3);
`endif

        // NOP payload with valid=1 passes unchanged
        flush      = 1'b0;
        stall      = 6'b000000;
        in_payload = 64'h0;
        in_valid   = 1'b1;
        in_sticky  = 1'b0;
        step();
        check_out("nop_valid", 64'h0, 1'b1, 1'b0);

        // Reset during hold wins
        in_payload = 64'h99;
        in_sticky  = 1'b1;
        step();
        check_out("advance4", 64'h99, 1'b1, 1'b1);
        stall = 6'b001111;
        rst   = 1'b1;
        step();
        check_out("rst_hold", 64'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_cnt("rst_hold", 0, 0);
`endif

        // Clean state then advance after reset
        rst        = 1'b0;
        stall      = 6'b000000;
        in_payload = 64'h42;
        in_valid   = 1'b1;
        in_sticky  = 1'b0;
        step();
        check_out("post_rst", 64'h42, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Saturation: 20 bubbles on a 4-bit counter
        stall = 6'b000111;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                check("sat.bubble_cnt", 128'(bubble_cnt), 128'((i > 15) ? 15 : i));
            end
        end
        check_out("sat", 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_cnt("sat_rst", 0, 0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
